// File: rtl/prg_loader.sv
// Byte-stream program loader: reads a 16-bit little-endian word count, then
// packs little-endian bytes into 32-bit words and writes them to instruction memory.
module prg_loader #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int              CNT_W     = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(TIMEOUT - 1);
    localparam logic [32:0]      MAX_WORDS = 33'(1) << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_DONE, ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    // One bit wider than the address so the index can reach N == 2^ADDR_W.
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       din_q, din_d;
    logic [CNT_W-1:0]  idle_q, idle_d;

    logic        accept;
    logic        timeout;
    logic [15:0] n_full;

    assign byte_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
    assign busy       = byte_ready || (state_q == ST_WRITE);
    assign mem_we     = (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign mem_addr   = widx_q[ADDR_W-1:0];
    assign mem_din    = din_q;

    assign accept  = byte_valid && byte_ready;
    assign timeout = (idle_q == IDLE_MAX);
    assign n_full  = {byte_data, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        din_d   = din_q;
        idle_d  = byte_ready ? idle_q + CNT_W'(1) : '0;
        if (accept) idle_d = '0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_LO;
                    len_d   = '0;
                    widx_d  = '0;
                    bidx_d  = '0;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = byte_data;
                    state_d    = ST_LEN_HI;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = byte_data;
                    if (n_full == 16'd0 || 33'(n_full) > MAX_WORDS) state_d = ST_ERR;
                    else                                              state_d = ST_DATA;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    din_d[{bidx_q, 3'b000} +: 8] = byte_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) state_d = ST_WRITE;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_WRITE: begin
                widx_d = widx_q + 1'b1;
                bidx_d = '0;
                if (33'(widx_q) + 33'd1 == 33'(len_q)) state_d = ST_DONE;
                else                                   state_d = ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase

        // Every state entry restarts the idle window.
        if (state_d != state_q) idle_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            din_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            din_q   <= din_d;
            idle_q  <= idle_d;
        end
    end

endmodule

// File: doc/prg_loader.md
PRG_LOADER -- requirements
Module: prg_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, giving the instruction-memory word-address width (16384 words).
REQ-002 The block SHALL have parameter TIMEOUT, default 1000000, giving the maximum number of idle clock cycles allowed between accepted bytes.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: single-cycle request to begin a load session.
REQ-006 Port byte_valid, input, 1 bit: byte_data is valid this cycle.
REQ-007 Port byte_data, input, 8 bits: incoming stream byte.
REQ-008 Port byte_ready, output, 1 bit: the loader can accept a byte this cycle.
REQ-009 Port mem_we, output, 1 bit: single-cycle write strobe to the instruction-memory write port.
REQ-010 Port mem_addr, output, ADDR_W bits: word address (memory addra).
REQ-011 Port mem_din, output, 32 bits: write data (memory dina).
REQ-012 Port busy, output, 1 bit: a session is in progress.
REQ-013 Port done, output, 1 bit: the last session completed successfully.
REQ-014 Port err, output, 1 bit: the last session aborted.

Function
REQ-015 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both 1.
REQ-016 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE and ERR.
REQ-017 A start pulse in IDLE, DONE or ERR SHALL move the FSM to LEN_LO and clear done, err, the word address and the byte index; start in any other state SHALL be ignored.
REQ-018 byte_ready SHALL be 1 only in LEN_LO, LEN_HI and DATA; busy SHALL be 1 in LEN_LO, LEN_HI, DATA and WRITE.
REQ-019 In LEN_LO the accepted byte SHALL become N[7:0]; in LEN_HI it SHALL become N[15:8], where N is the 16-bit word count.
REQ-020 On leaving LEN_HI, the FSM SHALL go to ERR if N == 0 or N > 2^ADDR_W, and to DATA otherwise.
REQ-021 In DATA the accepted bytes SHALL be packed little-endian: byte k of the word goes to mem_din[8k+7:8k], for k = 0..3.
REQ-022 Acceptance of the 4th byte SHALL move the FSM to WRITE; in the following cycle mem_we SHALL be 1 for exactly one cycle, with mem_addr = the current word index and mem_din = the assembled word.
REQ-023 On leaving WRITE, the word index SHALL increment by 1; if it now equals N the FSM SHALL go to DONE, otherwise to DATA with the byte index cleared.
REQ-024 The last write SHALL go to address N-1; the address SHALL never wrap within a session.
REQ-025 done SHALL be 1 in DONE; err SHALL be 1 in ERR; both SHALL hold until the next accepted start or reset.
REQ-026 The idle counter SHALL clear on every accepted byte and on every state entry, and SHALL count in LEN_LO, LEN_HI and DATA.
REQ-027 When the idle counter reaches TIMEOUT-1, the FSM SHALL go to ERR with no further writes.
REQ-028 Bytes presented outside LEN_LO, LEN_HI and DATA SHALL be dropped, since byte_ready is 0.
REQ-029 mem_we SHALL be 0 in every state except WRITE.

Reset
REQ-030 While reset is high, the FSM SHALL be IDLE and byte_ready, mem_we, busy, done and err SHALL all be 0; mem_addr, mem_din, N and all counters SHALL be 0.
REQ-031 Reset asserted mid-session SHALL abort the session immediately, with no further mem_we pulse and with the partial word discarded.

Verification
REQ-032 Directed test, normal load: start, then bytes 02 00 13 00 00 00 B3 00 10 00 with byte_valid held high -> writes of 0x00000013 at address 0 and 0x001000B3 at address 1, one mem_we cycle each, then done=1, busy=0.
REQ-033 Directed test, bad length: start, then bytes 00 00 -> err=1 with no mem_we; length bytes 01 40 (N=16385) -> err=1 with no mem_we.
REQ-034 Directed test, timeout (TIMEOUT=16): start, bytes 01 00 AA, then idle for 16 cycles -> err=1, no mem_we, byte_ready=0.
REQ-035 Directed test, backpressure: byte_valid asserted during WRITE -> that byte is not consumed and is accepted in the next DATA cycle; byte order in memory is preserved.
REQ-036 Directed test, mid-session reset: reset asserted after 2 data bytes -> all outputs 0; a new start with N=1 and bytes EF BE AD DE -> 0xDEADBEEF written at address 0, then done=1.
REQ-037 Directed test, start while busy: start pulsed in DATA is ignored and the session completes normally.
